core_mau_pl: RTL and testbench
==============================

Name: core_mau_pl

Overview:
Parametrised memory access unit, successor to the single-shot MAU. It accepts load/store requests from the execute stage and issues them as a pipelined Wishbone master. Up to DEPTH requests may be in flight. Byte, half and word accesses are supported, with lane select, store data replication, load sign/zero extension, misalignment trapping and bus-error reporting. Responses are returned in order, tagged with the destination register.

Parameters:
DW, 32, data width (multiple of 8; sizes above DW/8 bytes are illegal)
AW, 32, address width
DEPTH, 4, max outstanding requests (power of 2, ≥2)
RW, 4, destination register address width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  sign-extend load
req_addr  input  AW  byte address
req_wdata  input  DW  store data, right-aligned
req_rd  input  RW  load destination register
wb_cyc  output  1  bus cycle
wb_stb  output  1  strobe
wb_we  output  1  write enable
wb_adr  output  AW  address, low log2(DW/8) bits forced 0
wb_sel  output  DW/8  byte lane select
wb_dat_o  output  DW  write data
wb_dat_i  input  DW  read data
wb_ack  input  1  transfer done
wb_err  input  1  transfer error
wb_stall  input  1  slave cannot take strobe
rsp_valid  output  1  one-cycle response pulse
rsp_rd  output  RW  register tag of response
rsp_data  output  DW  extended load data (0 for stores/errors)
rsp_err  output  1  bus error, misaligned or illegal size
mau_busy  output  1  unit not idle

Behaviour:
- Reset (rst=0, async): wb_cyc/stb/we=0, adr/sel/dat_o=0, tracker count=0, rsp_valid=0, rsp_rd/data/err=0, mau_busy=0.
- req_ready = (count<DEPTH) & (!wb_stb | !wb_stall).
- On accept, push a tracker entry {we, size, signed, addr low bits, rd, lerr}.
- lerr=1 if size==11, or half with addr[0]!=0, or word with addr[1:0]!=0. An lerr request drives no strobe.
- Non-lerr accept: next cycle wb_stb=1, wb_cyc=1, we=req_we. sel = 1 lane (byte), 2 lanes (half), all lanes (word) at addr offset. dat_o = wdata low bytes replicated across all lanes.
- Strobe hold: wb_stb, adr, sel, dat_o are held while wb_stall=1. The strobe drops the cycle after stall is low unless a new request is accepted in the same cycle, which gives back-to-back strobes with no bubble.
- Tracker: DEPTH-entry FIFO with in-order retirement. Push and pop in the same cycle leave count unchanged. Push is refused when full.
- Retire head:
  - If head.lerr=1, it retires in the cycle it is head.
  - Otherwise it retires on wb_ack|wb_err.
  - ack and err together count as err.
  - ack/err with an empty tracker, or with head.lerr=1, is ignored.
- Response, registered, 1 cycle after retire:
  - Loads: rsp_valid=1, rsp_rd=head.rd, rsp_data = selected lane(s) shifted down, then sign- or zero-extended.
  - Stores: rsp_valid only when error.
  - Any error: rsp_err=1, rsp_data=0.
  - No response backpressure; the consumer must take the pulse.
- wb_cyc: set with the first strobe. Cleared the cycle after the last bus entry retires, if no strobe is pending and no non-lerr entry remains. Never cleared while a bus transfer is outstanding.
- mau_busy = wb_cyc | (count!=0) | rsp_valid.
- Minimum load latency: accept→strobe 1 cycle, ack same cycle as strobe, rsp_valid 1 cycle later.

Test Plan:
- Word load: addr 0x100, slave acks with dat_i=0xDEADBEEF on strobe cycle → sel=1111, rsp_valid next cycle, rsp_data=0xDEADBEEF, rsp_rd=tag, rsp_err=0.
- Signed byte load at 0x103 with dat_i=0x80xxxxxx → sel=1000, rsp_data=0xFFFFFF80. Unsigned variant → 0x00000080.
- Half store 0xABCD at 0x102 → sel=1100, dat_o=0xABCDABCD, we=1, no rsp_valid on ack.
- Four back-to-back loads, slave stalls 3 cycles, then acks one per cycle → req_ready=0 while full. Strobe and address held during stall. Four in-order responses. cyc drops after the fourth ack.
- Word load at 0x101 between two valid loads → no strobe for it. Responses in order: ok, rsp_err=1 with data 0, ok.
- wb_err on second of two stores → exactly one rsp_valid with rsp_err=1. Async reset asserted mid-burst → all outputs 0 immediately, count 0, later stray ack ignored.

Source files
------------

// File: rtl/core_mau_pl.sv
// core_mau_pl: pipelined Wishbone memory access unit.
// Accepts load/store requests, issues them as pipelined bus strobes, keeps up to
// DEPTH requests in an in-order tracker and returns tagged, extended responses.
module core_mau_pl #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  parameter int RW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [RW-1:0]   req_rd,
  output logic            wb_cyc,
  output logic            wb_stb,
  output logic            wb_we,
  output logic [AW-1:0]   wb_adr,
  output logic [DW/8-1:0] wb_sel,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack,
  input  logic            wb_err,
  input  logic            wb_stall,
  output logic            rsp_valid,
  output logic [RW-1:0]   rsp_rd,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            mau_busy
);

  localparam int LB = DW / 8;
  localparam int OW = (LB > 1) ? $clog2(LB) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Shift-aligned load data is cut to the access size, then sign/zero extended.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] sh,
                                                 input logic [1:0]    size,
                                                 input logic          sgn);
    logic [DW-1:0] r;
    logic          msb;
    int            nbits;
    case (size)
      2'b00:   nbits = 32'd8;
      2'b01:   nbits = 32'd16;
      default: nbits = 32'd32;
    endcase
    msb = 1'b0;
    for (int i = 0; i < DW; i++) msb = (i == nbits - 1) ? (sgn & sh[i]) : msb;
    for (int i = 0; i < DW; i++) r[i] = (i < nbits) ? sh[i] : msb;
    return r;
  endfunction

  // Tracker storage: one slot per outstanding request.
  logic [DEPTH-1:0] trk_we_q, trk_sgn_q, trk_lerr_q;
  logic [1:0]       trk_size_q [DEPTH];
  logic [OW-1:0]    trk_off_q  [DEPTH];
  logic [RW-1:0]    trk_rd_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, bus_cnt_q, bus_cnt_d;

  logic          stb_q, stb_d, we_q, we_d, cyc_q, cyc_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [LB-1:0] sel_q, sel_d;
  logic [DW-1:0] dat_q, dat_d;

  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [RW-1:0] rsp_rd_q, rsp_rd_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          ready_s, push_s, lerr_s, retire_s, bus_push_s, bus_pop_s, rsp_err_s;
  logic          head_we_s, head_sgn_s, head_lerr_s;
  logic [1:0]    head_size_s;
  logic [OW-1:0] head_off_s;
  logic [RW-1:0] head_rd_s;
  logic [LB-1:0] sel_mask_s, sel_new_s;
  logic [DW-1:0] dat_new_s, load_s;

  assign head_we_s   = trk_we_q[rd_ptr_q];
  assign head_sgn_s  = trk_sgn_q[rd_ptr_q];
  assign head_lerr_s = trk_lerr_q[rd_ptr_q];
  assign head_size_s = trk_size_q[rd_ptr_q];
  assign head_off_s  = trk_off_q[rd_ptr_q];
  assign head_rd_s   = trk_rd_q[rd_ptr_q];

  // Decode the incoming request: local error, lane mask and replicated store data.
  always_comb begin
    case (req_size)
      2'b00:   lerr_s = 1'b0;
      2'b01:   lerr_s = req_addr[0] || (LB < 2);
      2'b10:   lerr_s = (req_addr[1:0] != 2'b00) || (LB < 4);
      default: lerr_s = 1'b1;
    endcase
    case (req_size)
      2'b00:   sel_mask_s = LB'(1);
      2'b01:   sel_mask_s = LB'(3);
      default: sel_mask_s = LB'(15);
    endcase
    sel_new_s = sel_mask_s << req_addr[OW-1:0];
    dat_new_s = {DW{1'b0}};
    for (int b = 0; b < LB; b++) begin
      case (req_size)
        2'b00:   dat_new_s[8*b +: 8] = req_wdata[7:0];
        2'b01:   dat_new_s[8*b +: 8] = req_wdata[8*(b%2) +: 8];
        default: dat_new_s[8*b +: 8] = req_wdata[8*(b%4) +: 8];
      endcase
    end
  end

  // Handshake, tracker bookkeeping, strobe generation and response formation.
  always_comb begin
    ready_s    = (count_q != CW'(DEPTH)) && (!stb_q || !wb_stall);
    push_s     = req_valid && ready_s;
    retire_s   = (count_q != {CW{1'b0}}) && (head_lerr_s || wb_ack || wb_err);
    bus_push_s = push_s && !lerr_s;
    bus_pop_s  = retire_s && !head_lerr_s;
    count_d    = count_q + CW'(push_s) - CW'(retire_s);
    bus_cnt_d  = bus_cnt_q + CW'(bus_push_s) - CW'(bus_pop_s);
    wr_ptr_d   = push_s   ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = retire_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    sel_d = sel_q;
    dat_d = dat_q;
    if (stb_q && wb_stall) begin
      stb_d = 1'b1;
    end else if (bus_push_s) begin
      stb_d = 1'b1;
      we_d  = req_we;
      adr_d = req_addr & ~AW'(LB - 1);
      sel_d = sel_new_s;
      dat_d = dat_new_s;
    end else begin
      stb_d = 1'b0;
    end
    // Cycle stays up while any bus transfer is pending or outstanding.
    cyc_d = stb_d || (bus_cnt_d != {CW{1'b0}});

    load_s      = extend_load(wb_dat_i >> {head_off_s, 3'b000}, head_size_s, head_sgn_s);
    rsp_err_s   = head_lerr_s || wb_err;
    rsp_valid_d = retire_s && (!head_we_s || rsp_err_s);
    rsp_rd_d    = rsp_valid_d ? head_rd_s : {RW{1'b0}};
    rsp_err_d   = rsp_valid_d && rsp_err_s;
    rsp_data_d  = (rsp_valid_d && !rsp_err_s) ? load_s : {DW{1'b0}};
  end

  // State registers, tracker slot writes and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      bus_cnt_q   <= {CW{1'b0}};
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      adr_q       <= {AW{1'b0}};
      sel_q       <= {LB{1'b0}};
      dat_q       <= {DW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= {RW{1'b0}};
      rsp_data_q  <= {DW{1'b0}};
      rsp_err_q   <= 1'b0;
      trk_we_q    <= {DEPTH{1'b0}};
      trk_sgn_q   <= {DEPTH{1'b0}};
      trk_lerr_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        trk_size_q[i] <= 2'b00;
        trk_off_q[i]  <= {OW{1'b0}};
        trk_rd_q[i]   <= {RW{1'b0}};
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bus_cnt_q   <= bus_cnt_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      if (push_s) begin
        trk_we_q[wr_ptr_q]   <= req_we;
        trk_sgn_q[wr_ptr_q]  <= req_signed;
        trk_lerr_q[wr_ptr_q] <= lerr_s;
        trk_size_q[wr_ptr_q] <= req_size;
        trk_off_q[wr_ptr_q]  <= req_addr[OW-1:0];
        trk_rd_q[wr_ptr_q]   <= req_rd;
      end
    end
  end

  assign req_ready = ready_s;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_we     = we_q;
  assign wb_adr    = adr_q;
  assign wb_sel    = sel_q;
  assign wb_dat_o  = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mau_busy  = cyc_q || (count_q != {CW{1'b0}}) || rsp_valid_q;

endmodule

// File: tb/tb_core_mau_pl.sv
// tb_core_mau_pl: directed bench with a queue-based reference model of the MAU
// and a scripted pipelined Wishbone slave.
module tb_core_mau_pl;
  localparam int DW = 32, AW = 32, DEPTH = 4, RW = 4;

  logic clk, rst;
  logic req_valid, req_ready, req_we, req_signed;
  logic [1:0] req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [RW-1:0] req_rd;
  logic wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
  logic [AW-1:0] wb_adr;
  logic [3:0] wb_sel;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic rsp_valid, rsp_err, mau_busy;
  logic [RW-1:0] rsp_rd;
  logic [DW-1:0] rsp_data;

  core_mau_pl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall), .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mau_busy(mau_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit we; bit [1:0] size; bit sgn; bit [1:0] off; bit [RW-1:0] rd; bit lerr; } ent_t;
  typedef struct { bit [RW-1:0] rd; bit [31:0] data; bit err; } rsp_t;
  ent_t mq[$];
  rsp_t rsp_log[$];
  bit e_stb, e_we, e_cyc, e_rv, e_re;
  bit [31:0] e_adr, e_dat, e_rdata;
  bit [3:0] e_sel;
  bit [RW-1:0] e_rrd;

  function automatic bit is_lerr(bit [1:0] sz, bit [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic bit [3:0] lane_sel(bit [1:0] sz, bit [1:0] off);
    int nb = 1 << sz;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic bit [31:0] repl(bit [1:0] sz, bit [31:0] wd);
    int nb = 1 << sz;
    bit [31:0] r = 0;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % nb) +: 8];
    return r;
  endfunction

  function automatic bit [31:0] ld_val(bit [31:0] d, bit [1:0] sz, bit [1:0] off, bit sg);
    int nb = 1 << sz;
    longint unsigned v = 0;
    for (int k = 0; k < nb; k++) v |= longint'((d >> (8 * (int'(off) + k))) & 32'hFF) << (8 * k);
    if (sg && nb < 4 && ((v >> (8 * nb - 1)) & 1) != 0) v |= ~((64'd1 << (8 * nb)) - 1);
    return v[31:0];
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit rdy, acc, ln, ret, er;
    ent_t h, n;
    int nbus;
    if (!rst) begin
      mq.delete();
      e_stb = 0; e_we = 0; e_cyc = 0; e_adr = 0; e_sel = 0; e_dat = 0;
      e_rv = 0; e_re = 0; e_rrd = 0; e_rdata = 0;
    end else begin
      rdy = (mq.size() < DEPTH) && (!e_stb || !wb_stall);
      acc = req_valid && rdy;
      ln  = is_lerr(req_size, req_addr);
      ret = 0; er = 0; h = '{default: 0};
      if (mq.size() > 0) begin
        h = mq[0];
        if (h.lerr) begin ret = 1; er = 1; end
        else if (wb_ack || wb_err) begin ret = 1; er = wb_err; end
      end
      e_rv    = ret && (!h.we || er);
      e_re    = e_rv && er;
      e_rrd   = e_rv ? h.rd : '0;
      e_rdata = (e_rv && !er) ? ld_val(wb_dat_i, h.size, h.off, h.sgn) : 32'd0;
      if (!(e_stb && wb_stall)) begin
        e_stb = acc && !ln;
        if (e_stb) begin
          e_we  = req_we;
          e_adr = {req_addr[31:2], 2'b00};
          e_sel = lane_sel(req_size, req_addr[1:0]);
          e_dat = repl(req_size, req_wdata);
        end
      end
      if (ret) void'(mq.pop_front());
      if (acc) begin
        n = '{we: req_we, size: req_size, sgn: req_signed, off: req_addr[1:0], rd: req_rd, lerr: ln};
        mq.push_back(n);
      end
      nbus = 0;
      foreach (mq[i]) if (!mq[i].lerr) nbus++;
      e_cyc = e_stb || (nbus > 0);
    end
  end

  // Per-cycle comparison against the model, plus response logging.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", req_ready, (mq.size() < DEPTH) && (!e_stb || !wb_stall));
      chk("wb_cyc", wb_cyc, e_cyc);
      chk("wb_stb", wb_stb, e_stb);
      chk("mau_busy", mau_busy, e_cyc || (mq.size() != 0) || e_rv);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_stb) begin
        chk("wb_we", wb_we, e_we);
        chk("wb_adr", wb_adr, e_adr);
        chk("wb_sel", wb_sel, e_sel);
        chk("wb_dat_o", wb_dat_o, e_dat);
      end
      if (e_rv) begin
        chk("rsp_rd", rsp_rd, e_rrd);
        chk("rsp_data", rsp_data, e_rdata);
        chk("rsp_err", rsp_err, e_re);
      end
    end
    if (rsp_valid) rsp_log.push_back('{rd: rsp_rd, data: rsp_data, err: rsp_err});
  end

  // ---------------- scripted pipelined slave ----------------
  int stall_left = 0, pend = 0, ack_num = 0, err_at = -1;
  bit hold_acks = 0, force_ack = 0;
  logic [31:0] slv_dat = 32'd0;

  always @(posedge clk) begin
    if (!rst) begin
      pend = 0; wb_ack = 0; wb_err = 0; wb_stall = 0;
    end else begin
      if (wb_stb && !wb_stall) pend++;
      if (wb_ack || wb_err) begin
        if (pend > 0) pend--;
        ack_num++;
      end
      #2;
      wb_stall = wb_stb && (stall_left > 0);
      if (wb_stall) stall_left--;
      wb_ack = 0; wb_err = 0;
      if (!hold_acks && (pend > 0 || (wb_stb && !wb_stall))) begin
        if (ack_num == err_at) wb_err = 1; else wb_ack = 1;
      end
      if (force_ack) wb_ack = 1;
      wb_dat_i = slv_dat;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input bit we, input bit [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] rd);
    bit ok = 0;
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_rd = rd;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_stb();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_stb) begin ok = 1; break; end
    end
    chk("stb_timeout", ok, 1);
  endtask

  task automatic chk_rsp(input int idx, input bit [3:0] rd, input bit [31:0] data, input bit err);
    if (idx < rsp_log.size()) begin
      chk("log_rd", rsp_log[idx].rd, rd);
      chk("log_data", rsp_log[idx].data, data);
      chk("log_err", rsp_log[idx].err, err);
    end else begin
      chk("log_missing", rsp_log.size(), idx + 1);
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    wb_ack = 0; wb_err = 0; wb_stall = 0; wb_dat_i = 0;
    #1 rst = 0;
    #1 cmp_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk("rst_busy", mau_busy, 0);
    chk("rst_cyc", wb_cyc, 0);

    // Word load at 0x100.
    slv_dat = 32'hDEADBEEF;
    do_req(0, 2'd2, 0, 32'h100, 32'd0, 4'd5);
    wait_stb();
    chk("t1_sel", wb_sel, 4'b1111);
    chk("t1_adr", wb_adr, 32'h100);
    @(posedge clk); #1;
    idle(3);
    chk("t1_n", rsp_log.size(), 1);
    chk_rsp(0, 4'd5, 32'hDEADBEEF, 0);
    rsp_log.delete();

    // Signed and unsigned byte loads at 0x103.
    slv_dat = 32'h80123456;
    do_req(0, 2'd0, 1, 32'h103, 32'd0, 4'd6);
    wait_stb();
    chk("t2_sel", wb_sel, 4'b1000);
    @(posedge clk); #1;
    do_req(0, 2'd0, 0, 32'h103, 32'd0, 4'd7);
    idle(4);
    chk("t2_n", rsp_log.size(), 2);
    chk_rsp(0, 4'd6, 32'hFFFFFF80, 0);
    chk_rsp(1, 4'd7, 32'h00000080, 0);
    rsp_log.delete();

    // Half store 0xABCD at 0x102: no response on ack.
    do_req(1, 2'd1, 0, 32'h102, 32'h0000ABCD, 4'd0);
    wait_stb();
    chk("t3_sel", wb_sel, 4'b1100);
    chk("t3_dat", wb_dat_o, 32'hABCDABCD);
    chk("t3_we", wb_we, 1);
    chk("t3_adr", wb_adr, 32'h100);
    @(posedge clk); #1;
    idle(4);
    chk("t3_norsp", rsp_log.size(), 0);

    // Four back-to-back loads, acks held, last strobe stalled three cycles.
    hold_acks = 1;
    slv_dat = 32'h11223344;
    for (int k = 0; k < 4; k++) do_req(0, 2'd2, 0, 32'h300 + 32'(4 * k), 32'd0, 4'(k + 1));
    stall_left = 3;
    req_valid = 1; req_addr = 32'h310; req_rd = 4'd9;
    idle(3);
    chk("t4_full", req_ready, 0);
    chk("t4_stb_held", wb_stb, 1);
    chk("t4_adr_held", wb_adr, 32'h30C);
    req_valid = 0;
    hold_acks = 0;
    idle(12);
    chk("t4_n", rsp_log.size(), 4);
    for (int k = 0; k < 4; k++) chk_rsp(k, 4'(k + 1), 32'h11223344, 0);
    chk("t4_cyc_drop", wb_cyc, 0);
    rsp_log.delete();

    // Misaligned and illegal-size requests between good loads.
    slv_dat = 32'hCAFEF00D;
    do_req(0, 2'd2, 0, 32'h200, 32'd0, 4'd1);
    do_req(0, 2'd2, 0, 32'h101, 32'd0, 4'd2);
    do_req(0, 2'd2, 0, 32'h204, 32'd0, 4'd3);
    do_req(0, 2'd3, 0, 32'h208, 32'd0, 4'd4);
    idle(6);
    chk("t5_n", rsp_log.size(), 4);
    chk_rsp(0, 4'd1, 32'hCAFEF00D, 0);
    chk_rsp(1, 4'd2, 32'h0, 1);
    chk_rsp(2, 4'd3, 32'hCAFEF00D, 0);
    chk_rsp(3, 4'd4, 32'h0, 1);
    rsp_log.delete();

    // Bus error on the second of two stores.
    err_at = ack_num + 1;
    do_req(1, 2'd2, 0, 32'h400, 32'h11111111, 4'd8);
    do_req(1, 2'd2, 0, 32'h404, 32'h22222222, 4'd9);
    idle(5);
    err_at = -1;
    chk("t6_n", rsp_log.size(), 1);
    chk_rsp(0, 4'd9, 32'h0, 1);
    rsp_log.delete();

    // Asynchronous reset mid-burst, then a stray ack.
    hold_acks = 1;
    do_req(0, 2'd2, 0, 32'h500, 32'd0, 4'd1);
    do_req(0, 2'd2, 0, 32'h504, 32'd0, 4'd2);
    chk("t7_busy_pre", mau_busy, 1);
    #2 rst = 0;
    #1;
    chk("t7_cyc", wb_cyc, 0);
    chk("t7_stb", wb_stb, 0);
    chk("t7_we", wb_we, 0);
    chk("t7_adr", wb_adr, 0);
    chk("t7_sel", wb_sel, 0);
    chk("t7_dat", wb_dat_o, 0);
    chk("t7_rv", rsp_valid, 0);
    chk("t7_rrd", rsp_rd, 0);
    chk("t7_rdata", rsp_data, 0);
    chk("t7_rerr", rsp_err, 0);
    chk("t7_busy", mau_busy, 0);
    idle(2);
    rst = 1;
    hold_acks = 0;
    force_ack = 1;
    @(posedge clk); #1;
    force_ack = 0;
    idle(3);
    chk("t7_stray", rsp_log.size(), 0);
    slv_dat = 32'h0BADC0DE;
    do_req(0, 2'd2, 0, 32'h600, 32'd0, 4'd10);
    idle(3);
    chk("t7_n", rsp_log.size(), 1);
    chk_rsp(0, 4'd10, 32'h0BADC0DE, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
